// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store unit: funct3 codes, memory size and
// exception cause encodings, FSM states, decode result and lane helper.
package lsu_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned RD_W   = 5;

  // RV32I load/store funct3 codes (stores reuse the first three)
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    EXC_LD_MISALIGN = 2'b00,
    EXC_ST_MISALIGN = 2'b01,
    EXC_ACCESS      = 2'b10,
    EXC_ILLEGAL     = 2'b11
  } exc_cause_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RESP    = 3'd3,
    S_FAULT   = 3'd4
  } state_e;

  typedef struct packed {
    mem_size_e size;
    logic      is_unsigned;
    logic      illegal;
    logic      misaligned;
    logic      access_fault;
  } dec_t;

  // Replicate store data across all byte lanes so the RAM can pick any lane
  function automatic logic [DATA_W-1:0] lane_data(input mem_size_e size,
                                                  input logic [DATA_W-1:0] wdata);
    case (size)
      SZ_BYTE: lane_data = {4{wdata[7:0]}};
      SZ_HALF: lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational request decode.
// Ports: i_funct3/i_is_store select the access; i_ea_lo are the two low
// address bits, i_ea_hi the bits that must be zero; o_dec carries size,
// signedness and the three independent fault flags (priority is applied
// by the caller).
module lsu_decode
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 10
) (
  input  logic [F3_W-1:0]             i_funct3,
  input  logic                        i_is_store,
  input  logic [1:0]                  i_ea_lo,
  input  logic [DATA_W-ADDR_SIZE-1:0] i_ea_hi,
  output dec_t                        o_dec
);

  logic w_legal;

  always_comb begin
    w_legal = 1'b0;
    o_dec   = '0;

    case (i_funct3)
      F3_LB, F3_LH, F3_LW: w_legal = 1'b1;
      F3_LBU, F3_LHU:      w_legal = !i_is_store;
      default:             w_legal = 1'b0;
    endcase

    case (i_funct3[1:0])
      2'b00:   o_dec.size = SZ_BYTE;
      2'b01:   o_dec.size = SZ_HALF;
      default: o_dec.size = SZ_WORD;
    endcase

    o_dec.is_unsigned  = i_funct3[2];
    o_dec.illegal      = !w_legal;
    o_dec.misaligned   = ((o_dec.size == SZ_HALF) && i_ea_lo[0]) ||
                         ((o_dec.size == SZ_WORD) && (i_ea_lo != 2'b00));
    o_dec.access_fault = |i_ea_hi;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one request, computes and checks the effective
// address, drives one RAM strobe cycle, then returns a registered load
// result / store completion or a one-cycle exception.
// Ports: req_* execute-stage request (req_ready high in IDLE only),
// flush kills an in-flight response, resp_* writeback pulse, exc_* fault
// pulse, busy stall, mem_* data RAM port B (mem_dout valid the cycle
// after mem_en_read). All outputs are registered.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [F3_W-1:0]      req_funct3,
  input  logic [WORD_SIZE-1:0] req_base,
  input  logic [WORD_SIZE-1:0] req_offset,
  input  logic [WORD_SIZE-1:0] req_wdata,
  input  logic [RD_W-1:0]      req_rd,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic                 resp_we,
  output logic [RD_W-1:0]      resp_rd,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 exc_valid,
  output logic [1:0]           exc_cause,
  output logic [WORD_SIZE-1:0] exc_addr,
  output logic                 busy,
  output logic                 mem_en_write,
  output logic                 mem_en_read,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_din,
  output logic [1:0]           mem_size,
  output logic                 mem_unsigned,
  input  logic [WORD_SIZE-1:0] mem_dout
);

  state_e                 r_state, w_state_nxt;
  logic                   r_is_store, w_is_store_nxt;
  logic [RD_W-1:0]        r_rd, w_rd_nxt;
  logic                   r_req_ready, w_req_ready_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_resp_valid, w_resp_valid_nxt;
  logic                   r_resp_we, w_resp_we_nxt;
  logic [RD_W-1:0]        r_resp_rd, w_resp_rd_nxt;
  logic [WORD_SIZE-1:0]   r_resp_rdata, w_resp_rdata_nxt;
  logic                   r_exc_valid, w_exc_valid_nxt;
  exc_cause_e             r_exc_cause, w_exc_cause_nxt;
  logic [WORD_SIZE-1:0]   r_exc_addr, w_exc_addr_nxt;
  logic                   r_mem_en_write, w_mem_en_write_nxt;
  logic                   r_mem_en_read, w_mem_en_read_nxt;
  logic [ADDR_SIZE-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [WORD_SIZE-1:0]   r_mem_din, w_mem_din_nxt;
  mem_size_e              r_mem_size, w_mem_size_nxt;
  logic                   r_mem_unsigned, w_mem_unsigned_nxt;

  logic [WORD_SIZE-1:0]   w_ea;
  dec_t                   w_dec;
  logic                   w_fault;

  assign w_ea    = req_base + req_offset;
  assign w_fault = w_dec.illegal | w_dec.misaligned | w_dec.access_fault;

  lsu_decode #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_decode (
    .i_funct3   (req_funct3),
    .i_is_store (req_is_store),
    .i_ea_lo    (w_ea[1:0]),
    .i_ea_hi    (w_ea[WORD_SIZE-1:ADDR_SIZE]),
    .o_dec      (w_dec)
  );

  // Next state and next registered outputs; mem_addr/size/unsigned hold
  // through RD_WAIT because the RAM extends the read data from them.
  always_comb begin
    w_state_nxt        = r_state;
    w_is_store_nxt     = r_is_store;
    w_rd_nxt           = r_rd;
    w_resp_valid_nxt   = 1'b0;
    w_resp_we_nxt      = r_resp_we;
    w_resp_rd_nxt      = r_resp_rd;
    w_resp_rdata_nxt   = r_resp_rdata;
    w_exc_valid_nxt    = 1'b0;
    w_exc_cause_nxt    = r_exc_cause;
    w_exc_addr_nxt     = r_exc_addr;
    w_mem_en_write_nxt = 1'b0;
    w_mem_en_read_nxt  = 1'b0;
    w_mem_addr_nxt     = r_mem_addr;
    w_mem_din_nxt      = r_mem_din;
    w_mem_size_nxt     = r_mem_size;
    w_mem_unsigned_nxt = r_mem_unsigned;

    case (r_state)
      S_IDLE: begin
        if (req_valid && !flush) begin
          if (w_fault) begin
            w_state_nxt     = S_FAULT;
            w_exc_valid_nxt = 1'b1;
            w_exc_addr_nxt  = w_ea;
            if (w_dec.illegal)         w_exc_cause_nxt = EXC_ILLEGAL;
            else if (w_dec.misaligned) w_exc_cause_nxt = req_is_store ? EXC_ST_MISALIGN
                                                                      : EXC_LD_MISALIGN;
            else                       w_exc_cause_nxt = EXC_ACCESS;
          end else begin
            w_state_nxt        = S_ISSUE;
            w_is_store_nxt     = req_is_store;
            w_rd_nxt           = req_rd;
            w_mem_en_write_nxt = req_is_store;
            w_mem_en_read_nxt  = !req_is_store;
            w_mem_addr_nxt     = w_ea[ADDR_SIZE-1:0];
            w_mem_din_nxt      = lane_data(w_dec.size, req_wdata);
            w_mem_size_nxt     = w_dec.size;
            w_mem_unsigned_nxt = w_dec.is_unsigned;
          end
        end
      end
      S_ISSUE: begin
        // A store's write is already on the bus; flush only drops the response
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_is_store) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_we_nxt    = 1'b0;
          w_resp_rd_nxt    = r_rd;
          w_resp_rdata_nxt = '0;
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_we_nxt    = 1'b1;
          w_resp_rd_nxt    = r_rd;
          w_resp_rdata_nxt = mem_dout;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      S_FAULT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_is_store     <= 1'b0;
      r_rd           <= '0;
      r_req_ready    <= 1'b1;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_we      <= 1'b0;
      r_resp_rd      <= '0;
      r_resp_rdata   <= '0;
      r_exc_valid    <= 1'b0;
      r_exc_cause    <= EXC_LD_MISALIGN;
      r_exc_addr     <= '0;
      r_mem_en_write <= 1'b0;
      r_mem_en_read  <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_din      <= '0;
      r_mem_size     <= SZ_BYTE;
      r_mem_unsigned <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_is_store     <= w_is_store_nxt;
      r_rd           <= w_rd_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_busy         <= w_busy_nxt;
      r_resp_valid   <= w_resp_valid_nxt;
      r_resp_we      <= w_resp_we_nxt;
      r_resp_rd      <= w_resp_rd_nxt;
      r_resp_rdata   <= w_resp_rdata_nxt;
      r_exc_valid    <= w_exc_valid_nxt;
      r_exc_cause    <= w_exc_cause_nxt;
      r_exc_addr     <= w_exc_addr_nxt;
      r_mem_en_write <= w_mem_en_write_nxt;
      r_mem_en_read  <= w_mem_en_read_nxt;
      r_mem_addr     <= w_mem_addr_nxt;
      r_mem_din      <= w_mem_din_nxt;
      r_mem_size     <= w_mem_size_nxt;
      r_mem_unsigned <= w_mem_unsigned_nxt;
    end
  end

  assign req_ready    = r_req_ready;
  assign busy         = r_busy;
  assign resp_valid   = r_resp_valid;
  assign resp_we      = r_resp_we;
  assign resp_rd      = r_resp_rd;
  assign resp_rdata   = r_resp_rdata;
  assign exc_valid    = r_exc_valid;
  assign exc_cause    = r_exc_cause;
  assign exc_addr     = r_exc_addr;
  assign mem_en_write = r_mem_en_write;
  assign mem_en_read  = r_mem_en_read;
  assign mem_addr     = r_mem_addr;
  assign mem_din      = r_mem_din;
  assign mem_size     = r_mem_size;
  assign mem_unsigned = r_mem_unsigned;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl paired with a small data RAM model (registered read,
// combinational lane select/extension, lane-enabled writes).
module tb_lsu_ctrl;

  localparam int unsigned AW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_base = '0;
  logic [31:0] req_offset = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        busy;
  logic        mem_en_write, mem_en_read;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_dout;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_SIZE(AW), .WORD_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_rdata(resp_rdata), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_addr(exc_addr), .busy(busy),
    .mem_en_write(mem_en_write), .mem_en_read(mem_en_read), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_dout(mem_dout)
  );

  // ---------------- data RAM model ----------------
  logic [31:0] ram [256];
  logic [31:0] r_word;
  logic [7:0]  widx;
  logic [3:0]  lane_en;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign widx = mem_addr[AW-1:2];

  always_comb begin
    lane_en = 4'b0000;
    case (mem_size)
      2'b00:   lane_en = 4'b0001 << mem_addr[1:0];
      2'b01:   lane_en = mem_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always @(posedge clk) begin
    if (mem_en_write)
      for (int b = 0; b < 4; b++)
        if (lane_en[b]) ram[widx][8*b +: 8] <= mem_din[8*b +: 8];
    if (mem_en_read) r_word <= ram[widx];
  end

  always_comb begin
    bsel = r_word[8*mem_addr[1:0] +: 8];
    hsel = mem_addr[1] ? r_word[31:16] : r_word[15:0];
    case (mem_size)
      2'b00:   mem_dout = mem_unsigned ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      2'b01:   mem_dout = mem_unsigned ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
      default: mem_dout = r_word;
    endcase
  end

  // ---------------- checking infrastructure ----------------
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] rdata;
    logic [1:0]  cause;
    logic [31:0] din;
    logic [1:0]  size;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
    int   lat;
    int   sbase;
    int   nstb;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_strobe = 0;
  int n_pulse  = 0;
  logic [31:0] last_din;
  logic [1:0]  last_size;
  logic [AW-1:0] last_waddr;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] base,
                              input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                              input logic exc, input logic [31:0] rdata, input logic [1:0] cause,
                              input logic [31:0] din, input logic [1:0] size);
    vec_t v;
    v.st = st; v.f3 = f3; v.base = base; v.off = off; v.wd = wd; v.rd = rd;
    v.exc = exc; v.rdata = rdata; v.cause = cause; v.din = din; v.size = size;
    return v;
  endfunction

  // Scoreboard monitor: every completion/exception pulse pops one expectation
  always @(negedge clk) begin
    if (mem_en_read || mem_en_write) n_strobe++;
    if (mem_en_write) begin
      last_din = mem_din; last_size = mem_size; last_waddr = mem_addr;
    end
    if (resp_valid || exc_valid) begin
      n_pulse++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: resp_valid=%0b exc_valid=%0b", resp_valid, exc_valid);
      end else begin
        exp_t e;
        logic [31:0] ea;
        e  = sb.pop_front();
        ea = e.v.base + e.v.off;
        chk("pulse_kind", {30'b0, resp_valid, exc_valid}, e.v.exc ? 32'd1 : 32'd2);
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("strobes", 32'(n_strobe - e.sbase), 32'(e.nstb));
        if (e.v.exc) begin
          chk("exc_cause", {30'b0, exc_cause}, {30'b0, e.v.cause});
          chk("exc_addr", exc_addr, ea);
        end else begin
          chk("resp_we", {31'b0, resp_we}, {31'b0, !e.v.st});
          chk("resp_rd", {27'b0, resp_rd}, {27'b0, e.v.rd});
          chk("resp_rdata", resp_rdata, e.v.rdata);
          if (e.v.st) begin
            chk("mem_din", last_din, e.v.din);
            chk("mem_size", {30'b0, last_size}, {30'b0, e.v.size});
            chk("mem_waddr", {22'b0, last_waddr}, {22'b0, ea[AW-1:0]});
          end
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    req_is_store = v.st; req_funct3 = v.f3; req_base = v.base;
    req_offset = v.off; req_wdata = v.wd; req_rd = v.rd; req_valid = 1'b1;
  endtask

  function automatic exp_t mkexp(input vec_t v, input int acc, input int lat_extra, input int nstb_extra);
    exp_t e;
    e.v = v; e.acc = acc; e.sbase = n_strobe;
    e.lat  = (v.exc ? 1 : (v.st ? 2 : 3)) + lat_extra;
    e.nstb = (v.exc ? 0 : 1) + nstb_extra;
    return e;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("ready_wait", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Issue one request and check it through the scoreboard
  task automatic issue(input vec_t v);
    wait_ready();
    @(negedge clk);
    drive(v);
    @(posedge clk); #1;
    sb.push_back(mkexp(v, cyc, 0, 0));
    req_valid = 1'b0;
    wait_drain();
    @(negedge clk);
  endtask

  vec_t tbl[18];

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h04] = 32'h8070F0A5;  // byte 0x010
    ram[8'h08] = 32'h55667788;  // byte 0x020
    ram[8'h10] = 32'h11111111;  // byte 0x040

    //            st    f3      base          off           wdata         rd     exc   rdata         cause  din           size
    tbl[0]  = mk(1'b0, 3'b000, 32'h10,       32'd3,        32'h0,        5'd1,  1'b0, 32'hFFFFFF80, 2'd0, 32'h0,        2'd0);
    tbl[1]  = mk(1'b0, 3'b100, 32'h10,       32'd3,        32'h0,        5'd2,  1'b0, 32'h00000080, 2'd0, 32'h0,        2'd0);
    tbl[2]  = mk(1'b0, 3'b101, 32'h10,       32'd2,        32'h0,        5'd3,  1'b0, 32'h00008070, 2'd0, 32'h0,        2'd0);
    tbl[3]  = mk(1'b0, 3'b001, 32'h10,       32'd2,        32'h0,        5'd4,  1'b0, 32'hFFFF8070, 2'd0, 32'h0,        2'd0);
    tbl[4]  = mk(1'b0, 3'b010, 32'h10,       32'd0,        32'h0,        5'd5,  1'b0, 32'h8070F0A5, 2'd0, 32'h0,        2'd0);
    tbl[5]  = mk(1'b0, 3'b000, 32'h10,       32'd0,        32'h0,        5'd6,  1'b0, 32'hFFFFFFA5, 2'd0, 32'h0,        2'd0);
    tbl[6]  = mk(1'b1, 3'b001, 32'h20,       32'd2,        32'h1234ABCD, 5'd7,  1'b0, 32'h0,        2'd0, 32'hABCDABCD, 2'd1);
    tbl[7]  = mk(1'b0, 3'b010, 32'h20,       32'd0,        32'h0,        5'd8,  1'b0, 32'hABCD7788, 2'd0, 32'h0,        2'd0);
    tbl[8]  = mk(1'b0, 3'b010, 32'h20,       32'd2,        32'h0,        5'd9,  1'b1, 32'h0,        2'd0, 32'h0,        2'd0);
    tbl[9]  = mk(1'b1, 3'b001, 32'h20,       32'd1,        32'h0,        5'd10, 1'b1, 32'h0,        2'd1, 32'h0,        2'd0);
    tbl[10] = mk(1'b1, 3'b010, 32'h400,      32'd0,        32'h0,        5'd11, 1'b1, 32'h0,        2'd2, 32'h0,        2'd0);
    tbl[11] = mk(1'b0, 3'b011, 32'h400,      32'd1,        32'h0,        5'd12, 1'b1, 32'h0,        2'd3, 32'h0,        2'd0);
    tbl[12] = mk(1'b1, 3'b000, 32'hFFFFFFF0, 32'h41,       32'h000000EF, 5'd13, 1'b0, 32'h0,        2'd0, 32'hEFEFEFEF, 2'd0);
    tbl[13] = mk(1'b0, 3'b010, 32'h34,       32'hFFFFFFFC, 32'h0,        5'd14, 1'b0, 32'h0000EF00, 2'd0, 32'h0,        2'd0);
    tbl[14] = mk(1'b1, 3'b100, 32'h30,       32'd0,        32'h0,        5'd15, 1'b1, 32'h0,        2'd3, 32'h0,        2'd0);
    tbl[15] = mk(1'b1, 3'b010, 32'h3FC,      32'd0,        32'hCAFEF00D, 5'd16, 1'b0, 32'h0,        2'd0, 32'hCAFEF00D, 2'd2);
    tbl[16] = mk(1'b0, 3'b010, 32'h3FC,      32'd0,        32'h0,        5'd17, 1'b0, 32'hCAFEF00D, 2'd0, 32'h0,        2'd0);
    tbl[17] = mk(1'b0, 3'b010, 32'h7F0,      32'd14,       32'h0,        5'd18, 1'b1, 32'h0,        2'd0, 32'h0,        2'd0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_strobes", {30'b0, mem_en_read, mem_en_write}, 32'd0);
    chk("rst_pulses", {30'b0, resp_valid, exc_valid}, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 18; i++) issue(tbl[i]);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    drive(tbl[4]);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_busy", {31'b0, busy}, 32'd0);
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    // req_valid held high across two LWs
    begin
      vec_t v;
      int acc;
      v = mk(1'b0, 3'b010, 32'h10, 32'd0, 32'h0, 5'd20, 1'b0, 32'h8070F0A5, 2'd0, 32'h0, 2'd0);
      @(negedge clk);
      drive(v);
      @(posedge clk); #1;
      acc = cyc;
      sb.push_back(mkexp(v, acc, 0, 0));
      sb.push_back(mkexp(v, acc, 4, 1));
      for (int n = 1; n <= 3; n++) begin
        @(negedge clk);
        chk("b2b_ready_low", {31'b0, req_ready}, 32'd0);
      end
      @(negedge clk);
      chk("b2b_ready_c4", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_drain();
      @(negedge clk);
    end

    // Flush during RD_WAIT drops the load response
    begin
      vec_t v;
      int p0;
      v = mk(1'b0, 3'b010, 32'h10, 32'd0, 32'h0, 5'd21, 1'b0, 32'h0, 2'd0, 32'h0, 2'd0);
      p0 = n_pulse;
      @(negedge clk);
      drive(v);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_rdwait_idle", {31'b0, busy}, 32'd0);
      chk("flush_rdwait_ready", {31'b0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      chk("flush_rdwait_nopulse", 32'(n_pulse - p0), 32'd0);
    end

    // Reset during a store's ISSUE cycle: strobe drops at once, RAM untouched
    begin
      vec_t v;
      v = mk(1'b1, 3'b010, 32'h40, 32'd0, 32'hDEADBEEF, 5'd22, 1'b0, 32'h0, 2'd0, 32'h0, 2'd2);
      @(negedge clk);
      drive(v);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst_issue_strobe_on", {31'b0, mem_en_write}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_issue_strobe_off", {31'b0, mem_en_write}, 32'd0);
      chk("rst_issue_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(mk(1'b0, 3'b010, 32'h40, 32'd0, 32'h0, 5'd23, 1'b0, 32'h11111111, 2'd0, 32'h0, 2'd0));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
